// File: rtl/ft_tx_arbiter_if.sv
// Bundle of telemetry, loopback and FT transmit signals around ft_tx_arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface ft_tx_arbiter_if #(
  parameter int PKT_WIDTH = 88
);
  logic [PKT_WIDTH-1:0] tlm_data;
  logic                 tlm_valid;
  logic [15:0]          lb_din;
  logic [1:0]           lb_be;
  logic                 lb_empty;
  logic                 lb_get;
  logic [15:0]          ui_din;
  logic [1:0]           ui_din_be;
  logic                 ui_din_valid;
  logic                 ui_din_full;
  logic [15:0]          tlm_drop_count;
  logic                 busy;

  modport slave (
    input  tlm_data, tlm_valid, lb_din, lb_be, lb_empty, ui_din_full,
    output lb_get, ui_din, ui_din_be, ui_din_valid, tlm_drop_count, busy
  );

  modport master (
    output tlm_data, tlm_valid, lb_din, lb_be, lb_empty, ui_din_full,
    input  lb_get, ui_din, ui_din_be, ui_din_valid, tlm_drop_count, busy
  );
endinterface

// File: rtl/ft_tx_arbiter.sv
// Shares the FT USB transmit port between the loopback stream and framed
// telemetry packets, round-robin at packet granularity.
module ft_tx_arbiter #(
  parameter int          PKT_WIDTH = 88,
  parameter logic [15:0] HEADER    = 16'hA55A,
  parameter int          LB_BURST  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  ft_tx_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | dead cycle between grants; arbitration decision
  // TLM   | sending one 7-word telemetry frame
  // LB    | loopback pass-through, up to LB_BURST words
  localparam int BCW = (LB_BURST > 1) ? $clog2(LB_BURST) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TLM = 2'd1, S_LB = 2'd2} state_t;

  state_t               r_state;
  logic                 r_pending;
  logic                 r_last_tlm;
  logic [2:0]           r_word_idx;
  logic [BCW-1:0]       r_burst_cnt;
  logic [PKT_WIDTH-1:0] r_pkt;
  logic [15:0]          r_drop_cnt;

  logic [15:0] w_din;
  logic [1:0]  w_be;
  logic        w_valid;
  logic        w_get;
  logic        w_xfer;
  logic        w_frame_done;
  logic        w_burst_done;

  always_comb begin
    w_din   = '0;
    w_be    = '0;
    w_valid = 1'b0;
    w_get   = 1'b0;
    case (r_state)
      S_TLM: begin
        w_valid = 1'b1;
        w_be    = 2'b11;
        case (r_word_idx)
          3'd0:    w_din = HEADER;
          3'd1:    w_din = r_pkt[87:72];
          3'd2:    w_din = r_pkt[71:56];
          3'd3:    w_din = r_pkt[55:40];
          3'd4:    w_din = r_pkt[39:24];
          3'd5:    w_din = r_pkt[23:8];
          default: begin
            w_din = {8'h00, r_pkt[7:0]};
            w_be  = 2'b01;
          end
        endcase
      end
      S_LB: begin
        w_din   = bus.lb_din;
        w_be    = bus.lb_be;
        w_valid = !bus.lb_empty;
        w_get   = !bus.lb_empty && !bus.ui_din_full;
      end
      default: ;
    endcase
  end

  assign w_xfer       = w_valid && !bus.ui_din_full;
  assign w_frame_done = (r_state == S_TLM) && w_xfer && (r_word_idx == 3'd6);
  assign w_burst_done = w_xfer && (r_burst_cnt == BCW'(LB_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_last_tlm  <= 1'b0;
      r_word_idx  <= '0;
      r_burst_cnt <= '0;
      r_pkt       <= '0;
      r_drop_cnt  <= '0;
    end else begin
      // The final-word cycle frees the holding register, so a strobe there refills it.
      if (bus.tlm_valid) begin
        if (!r_pending || w_frame_done) begin
          r_pkt     <= bus.tlm_data;
          r_pending <= 1'b1;
        end else if (r_drop_cnt != 16'hFFFF) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end else if (w_frame_done) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pending && (!r_last_tlm || bus.lb_empty)) begin
            r_state    <= S_TLM;
            r_word_idx <= '0;
            r_last_tlm <= 1'b1;
          end else if (!bus.lb_empty) begin
            r_state     <= S_LB;
            r_burst_cnt <= '0;
            r_last_tlm  <= 1'b0;
          end
        end
        S_TLM: begin
          if (w_xfer) begin
            if (r_word_idx == 3'd6) begin
              r_state    <= S_IDLE;
              r_word_idx <= '0;
            end else begin
              r_word_idx <= r_word_idx + 3'd1;
            end
          end
        end
        S_LB: begin
          if (w_xfer) r_burst_cnt <= r_burst_cnt + BCW'(1);
          if (bus.lb_empty || w_burst_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ui_din         = w_din;
  assign bus.ui_din_be      = w_be;
  assign bus.ui_din_valid   = w_valid;
  assign bus.lb_get         = w_get;
  assign bus.tlm_drop_count = r_drop_cnt;
  assign bus.busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Scoreboard bench for ft_tx_arbiter: directed scenarios plus a randomized
// mix of loopback traffic, telemetry strobes and FT backpressure.
module tb_ft_tx_arbiter;
  localparam int          LB_BURST = 4;
  localparam logic [15:0] HDR      = 16'hA55A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft_tx_arbiter_if #(.PKT_WIDTH(88)) bus ();

  ft_tx_arbiter #(.PKT_WIDTH(88), .HEADER(HDR), .LB_BURST(LB_BURST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit t;
    int len;
  } grant_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [17:0] lb_fifo[$];
  logic [17:0] lb_exp[$];
  logic [87:0] tlm_exp[$];
  int          xfer_cyc[$];
  grant_t      glog[$];
  bit          mp = 1'b0;
  int          frame_idx = 0;
  logic [87:0] cur_pkt = '0;
  logic [15:0] exp_drops = '0;
  bit          pop_pend = 1'b0;
  int          run_len = 0;
  bit          run_t = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame built from its definition: header, five packet words MSB-first, last byte alone.
  function automatic logic [17:0] frame_word(input logic [87:0] p, input int i);
    if (i == 0) return {2'b11, HDR};
    if (i < 6) return {2'b11, 16'((p >> (88 - 16 * i)) & 88'hFFFF)};
    return {2'b01, 8'h00, p[7:0]};
  endfunction

  task automatic drive_lb();
    if (lb_fifo.size() == 0) begin
      bus.lb_empty = 1'b1;
      bus.lb_din   = 16'h0;
      bus.lb_be    = 2'b00;
    end else begin
      bus.lb_empty = 1'b0;
      {bus.lb_be, bus.lb_din} = lb_fifo[0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pend) begin
      if (lb_fifo.size() > 0) void'(lb_fifo.pop_front());
      pop_pend = 1'b0;
    end
    bus.tlm_valid = 1'b0;
    drive_lb();
  endtask

  task automatic lb_push(input logic [15:0] d, input logic [1:0] be);
    lb_fifo.push_back({be, d});
    lb_exp.push_back({be, d});
    drive_lb();
  endtask

  task automatic strobe(input logic [87:0] p);
    bus.tlm_valid = 1'b1;
    bus.tlm_data  = p;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    lb_fifo.delete();
    pop_pend = 1'b0;
    bus.tlm_valid = 1'b0;
    bus.ui_din_full = 1'b0;
    drive_lb();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xfer_cyc.delete();
    glog.delete();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    bus.ui_din_full = 1'b0;
    tick();
    while ((lb_fifo.size() != 0 || tlm_exp.size() != 0 || mp || bus.busy) && n < limit) begin
      tick();
      n++;
    end
    check("drain_in_time", 32'(n < limit), 32'd1);
    tick();
    tick();
    check("lb_words_left", 32'(lb_exp.size()), 32'd0);
  endtask

  task automatic check_grant(input int i, input bit t, input int len);
    if (i < glog.size()) begin
      check($sformatf("grant%0d_is_tlm", i), 32'(glog[i].t), 32'(t));
      check($sformatf("grant%0d_len", i), 32'(glog[i].len), 32'(len));
    end else begin
      check($sformatf("grant%0d_present", i), 32'(glog.size()), 32'(i + 1));
    end
  endtask

  task automatic note_run(input bit t);
    if (run_len > 0) check("one_stream_per_grant", 32'(run_t), 32'(t));
    run_t = t;
    run_len++;
  endtask

  // Monitor and reference model: pops expectations whenever a word transfers.
  always @(negedge clk) begin : mon
    bit          xfer;
    bit          last;
    bit          have;
    logic [17:0] got;
    logic [17:0] expw;
    last = 1'b0;
    if (!rst_n) begin
      lb_exp.delete();
      tlm_exp.delete();
      mp = 1'b0;
      frame_idx = 0;
      exp_drops = '0;
      run_len = 0;
      pop_pend = 1'b0;
    end else begin
      pop_pend = bus.lb_get;
      xfer = bus.ui_din_valid && !bus.ui_din_full;
      got = {bus.ui_din_be, bus.ui_din};
      check("drop_count", 32'(bus.tlm_drop_count), 32'(exp_drops));
      check("lb_get_only_on_write", 32'(bus.lb_get && !xfer), 32'd0);
      if (xfer) begin
        xfer_cyc.push_back(cyc);
        if (frame_idx > 0 || !bus.lb_get) begin
          have = (frame_idx > 0);
          if (frame_idx == 0) begin
            check("tlm_frame_expected", 32'(tlm_exp.size()), 32'd1);
            if (tlm_exp.size() > 0) begin
              cur_pkt = tlm_exp.pop_front();
              have = 1'b1;
            end
          end
          if (have) begin
            expw = frame_word(cur_pkt, frame_idx);
            check($sformatf("tlm_w%0d", frame_idx), 32'(got), 32'(expw));
            check("lb_get_in_frame", 32'(bus.lb_get), 32'd0);
            last = (frame_idx == 6);
            frame_idx = last ? 0 : frame_idx + 1;
          end
          note_run(1'b1);
        end else begin
          check("lb_word_expected", 32'(lb_exp.size() > 0), 32'd1);
          if (lb_exp.size() > 0) begin
            expw = lb_exp.pop_front();
            check("lb_word", 32'(got), 32'(expw));
          end
          note_run(1'b0);
        end
      end
      if (!bus.busy && run_len > 0) begin
        glog.push_back('{run_t, run_len});
        run_len = 0;
      end
      if (bus.tlm_valid) begin
        if (!mp || last) begin
          tlm_exp.push_back(bus.tlm_data);
          mp = 1'b1;
        end else if (exp_drops != 16'hFFFF) begin
          exp_drops = exp_drops + 16'd1;
        end
      end else if (last) begin
        mp = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    int          n;
    logic [87:0] p;
    bus.tlm_data    = '0;
    bus.tlm_valid   = 1'b0;
    bus.ui_din_full = 1'b0;
    drive_lb();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("rst_valid", 32'(bus.ui_din_valid), 32'd0);
    check("rst_din", 32'(bus.ui_din), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_lb_get", 32'(bus.lb_get), 32'd0);
    check("rst_drops", 32'(bus.tlm_drop_count), 32'd0);

    // Telemetry only
    do_reset();
    tick();
    c = cyc;
    strobe(88'h0102_0304_0506_0708_090A_0B);
    tick();
    #2;
    check("dead_cycle_valid", 32'(bus.ui_din_valid), 32'd0);
    check("dead_cycle_busy", 32'(bus.busy), 32'd0);
    repeat (7) tick();
    #2;
    check("busy_last_word", 32'(bus.busy), 32'd1);
    tick();
    #2;
    check("busy_after_frame", 32'(bus.busy), 32'd0);
    check("tlm_xfer_count", 32'(xfer_cyc.size()), 32'd7);
    for (int i = 0; i < 7 && i < xfer_cyc.size(); i++)
      check($sformatf("tlm_xfer_cycle%0d", i), 32'(xfer_cyc[i]), 32'(c + 2 + i));

    // Loopback only: one idle cycle every LB_BURST words
    do_reset();
    tick();
    c = cyc;
    for (int i = 0; i < 10; i++) lb_push(16'(i), 2'b11);
    repeat (20) tick();
    check("lb_xfer_count", 32'(xfer_cyc.size()), 32'd10);
    if (xfer_cyc.size() > 0) check("lb_first_cycle", 32'(xfer_cyc[0]), 32'(c + 1));
    for (int i = 1; i < 10 && i < xfer_cyc.size(); i++)
      check($sformatf("lb_gap%0d", i), 32'(xfer_cyc[i] - xfer_cyc[i-1]),
            (i % LB_BURST == 0) ? 32'd2 : 32'd1);
    check_grant(0, 1'b0, 4);
    check_grant(1, 1'b0, 4);
    check_grant(2, 1'b0, 2);
    check("lb_only_idle", 32'(bus.busy), 32'd0);

    // Contention: grants alternate, frames never split
    do_reset();
    tick();
    c = cyc;
    strobe(88'hDEAD_BEEF_0123_4567_89AB_CD);
    tick();
    for (int i = 0; i < 100; i++) lb_push(16'h1000 + 16'(i), 2'b11);
    while (cyc < c + 11) tick();
    strobe(88'h1111_2222_3333_4444_5555_66);
    n = 0;
    while (glog.size() < 5 && n < 200) begin
      tick();
      n++;
    end
    check_grant(0, 1'b1, 7);
    check_grant(1, 1'b0, 4);
    check_grant(2, 1'b1, 7);
    check_grant(3, 1'b0, 4);
    check_grant(4, 1'b0, 4);
    drain(1000);

    // Backpressure at word 3
    do_reset();
    tick();
    c = cyc;
    strobe(88'h0102_0304_0506_0708_090A_0B);
    repeat (5) tick();
    bus.ui_din_full = 1'b1;
    lb_push(16'hBEEF, 2'b10);
    lb_push(16'hCAFE, 2'b11);
    lb_push(16'hF00D, 2'b01);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      #2;
      check("stall_din", 32'(bus.ui_din), 32'h0506);
      check("stall_valid", 32'(bus.ui_din_valid), 32'd1);
      check("stall_lb_get", 32'(bus.lb_get), 32'd0);
    end
    tick();
    bus.ui_din_full = 1'b0;
    drain(200);
    check("bp_xfer_count", 32'(xfer_cyc.size()), 32'd10);
    if (xfer_cyc.size() > 3) check("bp_resume_cycle", 32'(xfer_cyc[3]), 32'(c + 25));

    // Drops, capture on the final-word cycle, saturation
    do_reset();
    tick();
    c = cyc;
    strobe(88'hA1A1_A2A2_A3A3_A4A4_A5A5_A6);
    tick(); tick();
    tick(); strobe(88'h1);
    tick();
    tick(); strobe(88'h2);
    tick();
    tick(); strobe(88'h3);
    tick(); strobe(88'h5151_5252_5353_5454_5555_56);
    tick();
    #2;
    check("drops_three", 32'(bus.tlm_drop_count), 32'd3);
    drain(200);
    check("drop_xfer_count", 32'(xfer_cyc.size()), 32'd14);
    if (xfer_cyc.size() > 7) check("recapture_frame_cycle", 32'(xfer_cyc[7]), 32'(c + 10));
    check("drops_unchanged", 32'(bus.tlm_drop_count), 32'd3);

    tick();
    force dut.r_drop_cnt = 16'hFFFE;
    exp_drops = 16'hFFFE;
    tick();
    release dut.r_drop_cnt;
    tick();
    strobe(88'h0F0F_0F0F_0F0F_0F0F_0F0F_0F);
    tick();
    tick(); strobe(88'h7);
    tick(); strobe(88'h8);
    tick();
    tick();
    #2;
    check("drops_saturated", 32'(bus.tlm_drop_count), 32'hFFFF);
    drain(200);

    // Asynchronous reset in the middle of a frame
    do_reset();
    tick();
    strobe(88'h0102_0304_0506_0708_090A_0B);
    repeat (4) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.ui_din_valid), 32'd0);
    check("arst_din", 32'(bus.ui_din), 32'd0);
    check("arst_be", 32'(bus.ui_din_be), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_lb_get", 32'(bus.lb_get), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    xfer_cyc.delete();
    for (int i = 0; i < 15; i++) begin
      tick();
      #2;
      check("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    check("post_rst_no_frame", 32'(xfer_cyc.size()), 32'd0);

    // Randomized mix
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      tick();
      bus.ui_din_full = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) < 6) begin
        p = 88'({$urandom, $urandom, $urandom});
        strobe(p);
      end
      if ($urandom_range(0, 99) < 35 && lb_fifo.size() < 40)
        lb_push(16'($urandom), 2'($urandom_range(0, 3)));
    end
    drain(3000);
    foreach (glog[i]) begin
      if (glog[i].t) check("rand_frame_len", 32'(glog[i].len), 32'd7);
      else check("rand_burst_len_ok", 32'(glog[i].len >= 1 && glog[i].len <= LB_BURST), 32'd1);
    end
    check("rand_some_grants", 32'(glog.size() > 10), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
